csr_exc_sched: RTL
==================

// Module: csr_exc_sched
// PURPOSE
// - Commit-point scheduler for the CSR exception datapath; sits between the WB stage and the CSR file.
// - Each cycle it picks one WB event (interrupt, exception, ertn, fetch-again, idle) by fixed priority.
// - It drives one-cycle commit pulses into the CSR file and sequences pipeline flush/stall around the redirect.
// - It parks the core in SLEEP after idle and wakes it on an enabled interrupt.
// PARAMETERS
// - INT_NUM    12     interrupt lines, matches the CSR is/lie width
// - EXCODE_INT 6'h00  excode issued for an interrupt
// - PERF_W     32     width of the perf counters (CSR_EXC_SCHED_PERF_EN only)
// PORTS
// - clk             in   1   core clock
// - resetn          in   1   asynchronous, active-low reset
// - wb_valid        in   1   a valid instruction is at the WB commit point
// - wb_is_exc       in   1   the WB instruction raised a synchronous exception
// - wb_excode       in   6   excode of that exception
// - wb_esubcode     in   9   esubcode of that exception
// - wb_badv         in   32  bad virtual address of that exception
// - wb_pc           in   32  PC of the WB instruction
// - wb_is_ertn      in   1   the WB instruction is ertn
// - wb_is_fetch_again in 1   the WB instruction is a TLB/CSR op that needs a refetch
// - wb_is_idle      in   1   the WB instruction is idle
// - csr_is          in   12  pending interrupt bits from the CSR file
// - csr_lie         in   12  interrupt enable bits from the CSR file
// - csr_ie          in   1   global interrupt enable, CRMD.IE
// - csr_exlike      in   1   CSR redirect valid, registered one cycle after a pulse
// - is_exc, is_ertn, is_fetch_again, is_idle  out  1 each  one-cycle commit pulses to the CSR file
// - excode          out  6   excode that accompanies is_exc
// - esubcode        out  9   esubcode that accompanies is_exc
// - badvaddr        out  32  bad address that accompanies is_exc
// - csr_pc          out  32  PC that accompanies every pulse
// - flush           out  1   kill IF..MEM
// - wb_stall        out  1   freeze WB; wb_* are held stable
// - sleeping        out  1   the core is in SLEEP
// - exc_cnt, int_cnt  out  PERF_W  perf counters (CSR_EXC_SCHED_PERF_EN only)
// BEHAVIOUR
// - Reset: all outputs 0, state RUN. A reset mid-sequence drops any pending pulse; no partial commit.
// - int_req  = wb_valid & csr_ie & |(csr_is & csr_lie).
// - wake_req = |(csr_is & csr_lie). Wake ignores csr_ie.
// - RUN, event priority in the same cycle:
//   1. int_req
//   2. wb_is_exc
//   3. wb_is_ertn
//   4. wb_is_fetch_again
//   5. wb_is_idle
//   No event: plain retire; stay in RUN; all outputs 0.
// - On an event at cycle N: latch the fields; go to ISSUE.
// - ISSUE, cycle N+1:
//   - Exactly one pulse is high, plus flush=1 and wb_stall=1.
//   - An interrupt issues is_exc with excode=EXCODE_INT, esubcode=0, badvaddr=0, csr_pc=wb_pc.
//   - The idle pulse goes to SLEEP; every other pulse goes to REDIRECT.
// - REDIRECT: flush=1, wb_stall=1, no pulses.
//   - Exit to RUN on the first cycle csr_exlike=1, nominally N+2.
//   - If csr_exlike is absent 4 cycles after ISSUE, that is a protocol error: assert and return to RUN.
// - SLEEP: sleeping=1, wb_stall=1, flush=0; wb_valid is ignored.
//   - On wake_req with csr_ie=1: ISSUE is_exc(INT) with csr_pc = the idle PC. The CSR file sets ERA = pc+4.
//   - On wake_req with csr_ie=0: ISSUE is_fetch_again with csr_pc = the idle PC, so fetch resumes at pc+4.
// - Any WB event seen outside RUN is ignored; wb_stall guarantees the event is held.
// - All outputs are registered; no combinational path from wb_* to the pulses.
// - Latency: event to pulse is 1 cycle; pulse to RUN is 2 cycles nominal.
// CONFIGURATION
// - CSR_EXC_SCHED_PERF_EN defined:
//   - exc_cnt +1 on each is_exc pulse with excode != EXCODE_INT.
//   - int_cnt +1 on each interrupt issue.
//   - Both saturate at all-ones and reset to 0.
// - CSR_EXC_SCHED_PERF_EN undefined: the exc_cnt/int_cnt ports and their logic are absent; behaviour is otherwise identical.
// TESTING
// - wb_is_exc, excode=6'h09, pc=0x1c00_0100 at N -> N+1 is_exc=1, excode=09, csr_pc=1c000100, flush=1; csr_exlike at N+2 -> RUN at N+3.
// - Same cycle: int_req and wb_is_exc (excode 0x09) -> is_exc with excode=0x00; the 0x09 is dropped.
// - wb_is_idle, pc=0x80 -> is_idle, then SLEEP; 20 idle cycles with sleeping=1, flush=0; csr_is[11]=lie[11]=1, ie=1 -> is_exc(INT), csr_pc=0x80.
// - SLEEP with ie=0, then interrupt pending -> is_fetch_again, csr_pc=idle pc, back to RUN.
// - resetn low during REDIRECT -> all outputs 0 immediately; after release, RUN with no stray pulse.
// - PERF_EN, 3 exceptions + 2 interrupts -> exc_cnt=3, int_cnt=2; counter forced to max -> holds at max.

Source files
------------

// File: rtl/csr_exc_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_exc_sched_if
// Description : Bundles the WB-stage event inputs, CSR-file status inputs and
//               the commit/flush/stall outputs of csr_exc_sched.
//               master : WB stage + CSR file side (drives wb_*/csr_*)
//               slave  : the scheduler (drives pulses, flush, stall, sleep)
// Ports       : wb_valid, wb_is_exc, wb_excode[5:0], wb_esubcode[8:0],
//               wb_badv[31:0], wb_pc[31:0], wb_is_ertn, wb_is_fetch_again,
//               wb_is_idle, csr_is/csr_lie[INT_NUM-1:0], csr_ie, csr_exlike
//               -> is_exc, is_ertn, is_fetch_again, is_idle, excode,
//               esubcode, badvaddr, csr_pc, flush, wb_stall, sleeping
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_exc_sched_if #(
    parameter int INT_NUM = 12
);
    // WB commit point
    logic               wb_valid;
    logic               wb_is_exc;
    logic [5:0]         wb_excode;
    logic [8:0]         wb_esubcode;
    logic [31:0]        wb_badv;
    logic [31:0]        wb_pc;
    logic               wb_is_ertn;
    logic               wb_is_fetch_again;
    logic               wb_is_idle;
    // CSR file status
    logic [INT_NUM-1:0] csr_is;
    logic [INT_NUM-1:0] csr_lie;
    logic               csr_ie;
    logic               csr_exlike;
    // Commit pulses and payload
    logic               is_exc;
    logic               is_ertn;
    logic               is_fetch_again;
    logic               is_idle;
    logic [5:0]         excode;
    logic [8:0]         esubcode;
    logic [31:0]        badvaddr;
    logic [31:0]        csr_pc;
    // Pipeline control
    logic               flush;
    logic               wb_stall;
    logic               sleeping;

    modport master (
        output wb_valid, wb_is_exc, wb_excode, wb_esubcode, wb_badv, wb_pc,
               wb_is_ertn, wb_is_fetch_again, wb_is_idle,
               csr_is, csr_lie, csr_ie, csr_exlike,
        input  is_exc, is_ertn, is_fetch_again, is_idle,
               excode, esubcode, badvaddr, csr_pc,
               flush, wb_stall, sleeping
    );

    modport slave (
        input  wb_valid, wb_is_exc, wb_excode, wb_esubcode, wb_badv, wb_pc,
               wb_is_ertn, wb_is_fetch_again, wb_is_idle,
               csr_is, csr_lie, csr_ie, csr_exlike,
        output is_exc, is_ertn, is_fetch_again, is_idle,
               excode, esubcode, badvaddr, csr_pc,
               flush, wb_stall, sleeping
    );
endinterface
`default_nettype wire

// File: rtl/csr_exc_sched.sv
`default_nettype none
// ============================================================================
// Module      : csr_exc_sched
// Description : Commit-point scheduler for the CSR exception datapath.
//               Picks one WB event per cycle by fixed priority
//               (interrupt > exception > ertn > fetch-again > idle), issues a
//               one-cycle commit pulse to the CSR file, and holds flush/stall
//               until the CSR redirect (csr_exlike) arrives. After idle the
//               core is parked in SLEEP until an enabled interrupt is pending.
// Ports       : clk, resetn (async, active-low)
//               bus  (csr_exc_sched_if.slave) - WB/CSR inputs, pulses,
//                    payload, flush, wb_stall, sleeping
//               exc_cnt, int_cnt [PERF_W-1:0] - perf counters, present only
//                    with CSR_EXC_SCHED_PERF_EN defined
// Options     : `define CSR_EXC_SCHED_PERF_EN adds saturating exception and
//               interrupt counters.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_exc_sched #(
    parameter int         INT_NUM    = 12,
`ifdef CSR_EXC_SCHED_PERF_EN
    parameter int         PERF_W     = 32,
`endif
    parameter logic [5:0] EXCODE_INT = 6'h00
) (
    input  wire                 clk,
    input  wire                 resetn,
`ifdef CSR_EXC_SCHED_PERF_EN
    output logic [PERF_W-1:0]   exc_cnt,
    output logic [PERF_W-1:0]   int_cnt,
`endif
    csr_exc_sched_if.slave      bus
);

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_ISSUE    = 2'd1;
    localparam logic [1:0] c_ST_REDIRECT = 2'd2;
    localparam logic [1:0] c_ST_SLEEP    = 2'd3;

    // Last REDIRECT wait index; four REDIRECT cycles without csr_exlike is an error.
    localparam logic [1:0] c_WAIT_LAST   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         r_wait;
    logic [31:0]        r_pc_hold;      // PC of the last event; the idle PC while sleeping
    logic               r_is_exc;
    logic               r_is_ertn;
    logic               r_is_fa;
    logic               r_is_idle;
    logic [5:0]         r_excode;
    logic [8:0]         r_esubcode;
    logic [31:0]        r_badv;
    logic [31:0]        r_csr_pc;
    logic               r_flush;
    logic               r_stall;
    logic               r_sleeping;

    logic [INT_NUM-1:0] w_pend;
    logic               w_wake_req;
    logic               w_int_req;

    logic [1:0]         w_nxt_state;
    logic [1:0]         w_nxt_wait;
    logic [31:0]        w_nxt_pc_hold;
    logic               w_nxt_exc;
    logic               w_nxt_ertn;
    logic               w_nxt_fa;
    logic               w_nxt_idle;
    logic [5:0]         w_nxt_excode;
    logic [8:0]         w_nxt_esubcode;
    logic [31:0]        w_nxt_badv;
    logic [31:0]        w_nxt_csr_pc;
    logic               w_nxt_flush;
    logic               w_nxt_stall;
    logic               w_nxt_sleeping;
    logic               w_int_issue;
    logic               w_proto_err;

    assign w_pend     = bus.csr_is & bus.csr_lie;
    assign w_wake_req = |w_pend;
    assign w_int_req  = bus.wb_valid & bus.csr_ie & w_wake_req;

    // Next-state and next-output logic. Every output is the registered copy
    // of these values, so no wb_* input reaches a pulse combinationally.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_wait     = r_wait;
        w_nxt_pc_hold  = r_pc_hold;
        w_nxt_exc      = 1'b0;
        w_nxt_ertn     = 1'b0;
        w_nxt_fa       = 1'b0;
        w_nxt_idle     = 1'b0;
        w_nxt_excode   = 6'd0;
        w_nxt_esubcode = 9'd0;
        w_nxt_badv     = 32'd0;
        w_nxt_csr_pc   = 32'd0;
        w_nxt_flush    = 1'b0;
        w_nxt_stall    = 1'b0;
        w_nxt_sleeping = 1'b0;
        w_int_issue    = 1'b0;
        w_proto_err    = 1'b0;

        case (r_state)
            c_ST_RUN: begin
                if (w_int_req) begin
                    w_nxt_exc    = 1'b1;
                    w_nxt_excode = EXCODE_INT;
                    w_int_issue  = 1'b1;
                end else if (bus.wb_valid && bus.wb_is_exc) begin
                    w_nxt_exc      = 1'b1;
                    w_nxt_excode   = bus.wb_excode;
                    w_nxt_esubcode = bus.wb_esubcode;
                    w_nxt_badv     = bus.wb_badv;
                end else if (bus.wb_valid && bus.wb_is_ertn) begin
                    w_nxt_ertn = 1'b1;
                end else if (bus.wb_valid && bus.wb_is_fetch_again) begin
                    w_nxt_fa = 1'b1;
                end else if (bus.wb_valid && bus.wb_is_idle) begin
                    w_nxt_idle = 1'b1;
                end

                if (w_nxt_exc || w_nxt_ertn || w_nxt_fa || w_nxt_idle) begin
                    w_nxt_state   = c_ST_ISSUE;
                    w_nxt_csr_pc  = bus.wb_pc;
                    w_nxt_pc_hold = bus.wb_pc;
                    w_nxt_flush   = 1'b1;
                    w_nxt_stall   = 1'b1;
                end
            end

            c_ST_ISSUE: begin
                if (r_is_idle) begin
                    w_nxt_state    = c_ST_SLEEP;
                    w_nxt_sleeping = 1'b1;
                    w_nxt_stall    = 1'b1;
                end else begin
                    w_nxt_state = c_ST_REDIRECT;
                    w_nxt_wait  = 2'd0;
                    w_nxt_flush = 1'b1;
                    w_nxt_stall = 1'b1;
                end
            end

            c_ST_REDIRECT: begin
                if (bus.csr_exlike) begin
                    w_nxt_state = c_ST_RUN;
                end else if (r_wait == c_WAIT_LAST) begin
                    // The CSR file never answered; recover rather than hang.
                    w_nxt_state = c_ST_RUN;
                    w_proto_err = 1'b1;
                end else begin
                    w_nxt_wait  = r_wait + 2'd1;
                    w_nxt_flush = 1'b1;
                    w_nxt_stall = 1'b1;
                end
            end

            c_ST_SLEEP: begin
                // Wake ignores CRMD.IE; IE only picks between taking the
                // interrupt and simply resuming after the idle.
                if (w_wake_req) begin
                    if (bus.csr_ie) begin
                        w_nxt_exc    = 1'b1;
                        w_nxt_excode = EXCODE_INT;
                        w_int_issue  = 1'b1;
                    end else begin
                        w_nxt_fa = 1'b1;
                    end
                    w_nxt_state  = c_ST_ISSUE;
                    w_nxt_csr_pc = r_pc_hold;
                    w_nxt_flush  = 1'b1;
                    w_nxt_stall  = 1'b1;
                end else begin
                    w_nxt_sleeping = 1'b1;
                    w_nxt_stall    = 1'b1;
                end
            end

            default: begin
                w_nxt_state = c_ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_ST_RUN;
            r_wait     <= 2'd0;
            r_pc_hold  <= 32'd0;
            r_is_exc   <= 1'b0;
            r_is_ertn  <= 1'b0;
            r_is_fa    <= 1'b0;
            r_is_idle  <= 1'b0;
            r_excode   <= 6'd0;
            r_esubcode <= 9'd0;
            r_badv     <= 32'd0;
            r_csr_pc   <= 32'd0;
            r_flush    <= 1'b0;
            r_stall    <= 1'b0;
            r_sleeping <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_wait     <= w_nxt_wait;
            r_pc_hold  <= w_nxt_pc_hold;
            r_is_exc   <= w_nxt_exc;
            r_is_ertn  <= w_nxt_ertn;
            r_is_fa    <= w_nxt_fa;
            r_is_idle  <= w_nxt_idle;
            r_excode   <= w_nxt_excode;
            r_esubcode <= w_nxt_esubcode;
            r_badv     <= w_nxt_badv;
            r_csr_pc   <= w_nxt_csr_pc;
            r_flush    <= w_nxt_flush;
            r_stall    <= w_nxt_stall;
            r_sleeping <= w_nxt_sleeping;
        end
    end

    assign bus.is_exc         = r_is_exc;
    assign bus.is_ertn        = r_is_ertn;
    assign bus.is_fetch_again = r_is_fa;
    assign bus.is_idle        = r_is_idle;
    assign bus.excode         = r_excode;
    assign bus.esubcode       = r_esubcode;
    assign bus.badvaddr       = r_badv;
    assign bus.csr_pc         = r_csr_pc;
    assign bus.flush          = r_flush;
    assign bus.wb_stall       = r_stall;
    assign bus.sleeping       = r_sleeping;

    // csr_exlike must follow every non-idle pulse within four REDIRECT cycles.
    a_exlike_timeout: assert property (@(posedge clk) disable iff (!resetn) !w_proto_err);

`ifdef CSR_EXC_SCHED_PERF_EN
    logic [PERF_W-1:0] r_exc_cnt;
    logic [PERF_W-1:0] r_int_cnt;

    // Counted on the edge that raises the pulse; both saturate at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_exc_cnt <= '0;
            r_int_cnt <= '0;
        end else begin
            if (w_nxt_exc && (w_nxt_excode != EXCODE_INT) && (r_exc_cnt != '1)) begin
                r_exc_cnt <= r_exc_cnt + PERF_W'(1);
            end
            if (w_int_issue && (r_int_cnt != '1)) begin
                r_int_cnt <= r_int_cnt + PERF_W'(1);
            end
        end
    end

    assign exc_cnt = r_exc_cnt;
    assign int_cnt = r_int_cnt;
`endif

endmodule
`default_nettype wire
